// File: rtl/hash_table_stream_adapter.sv
// Stream front end for hash_table: skid input, credit-gated issue, tagged response FIFO.
// Define HT_STATS_EN to add the stat_o per-op / error counters.

module hash_table #(
    parameter int KEY_WIDTH           = 5,
    parameter int DATA_WIDTH          = 25,
    parameter int NUMBER_OF_TABLES    = 8,
    parameter int HASH_TABLE_MAX_SIZE = 5,
    parameter logic [NUMBER_OF_TABLES*32-1:0] HASH_TABLE_SIZES = {8{32'd5}},
    parameter int BUCKET_SIZE         = 2,
    parameter int CAM_SIZE            = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH-1:0] matrixes_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [1:0]            op_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  key_already_present_o,
    output logic                  no_element_found_o,
    output logic                  no_write_space_o,
    output logic                  no_deletion_target_o
);
    localparam int CAP = NUMBER_OF_TABLES * BUCKET_SIZE + CAM_SIZE;
    localparam int IW  = $clog2(CAP);
    localparam int unused_sizes = HASH_TABLE_MAX_SIZE + int'(HASH_TABLE_SIZES[31:0]);

    logic                  unused_matrix;
    logic [CAP-1:0]        used;
    logic [KEY_WIDTH-1:0]  keys [CAP];
    logic [DATA_WIDTH-1:0] vals [CAP];
    logic                  hit;
    logic [IW-1:0]         hit_idx;
    logic                  has_free;
    logic [IW-1:0]         free_idx;
    logic                  fire;

    assign unused_matrix = ^matrixes_i;
    assign ready_o = ready_i | ~valid_o;
    assign fire    = valid_i & ready_o;

    // Descending scan so the lowest matching / free slot wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = CAP - 1; i >= 0; i--) begin
            if (used[i] && keys[i] == key_i) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!used[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            used                  <= '0;
            valid_o               <= 1'b0;
            read_data_o           <= '0;
            key_already_present_o <= 1'b0;
            no_element_found_o    <= 1'b0;
            no_write_space_o      <= 1'b0;
            no_deletion_target_o  <= 1'b0;
        end else if (fire) begin
            valid_o               <= 1'b1;
            read_data_o           <= '0;
            key_already_present_o <= 1'b0;
            no_element_found_o    <= 1'b0;
            no_write_space_o      <= 1'b0;
            no_deletion_target_o  <= 1'b0;
            case (op_i)
                2'b01: begin
                    if (hit) read_data_o <= vals[hit_idx];
                    else     no_element_found_o <= 1'b1;
                end
                2'b10: begin
                    if (hit) begin
                        key_already_present_o <= 1'b1;
                    end else if (has_free) begin
                        used[free_idx] <= 1'b1;
                        keys[free_idx] <= key_i;
                        vals[free_idx] <= data_i;
                    end else begin
                        no_write_space_o <= 1'b1;
                    end
                end
                2'b11: begin
                    if (hit) used[hit_idx] <= 1'b0;
                    else     no_deletion_target_o <= 1'b1;
                end
                default: ;
            endcase
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

module hash_table_stream_adapter #(
    parameter int KEY_WIDTH           = 5,
    parameter int DATA_WIDTH          = 25,
    parameter int NUMBER_OF_TABLES    = 8,
    parameter int HASH_TABLE_MAX_SIZE = 5,
    parameter logic [NUMBER_OF_TABLES*32-1:0] HASH_TABLE_SIZES = {8{32'd5}},
    parameter int BUCKET_SIZE         = 2,
    parameter int CAM_SIZE            = 8,
    parameter int TAG_WIDTH           = 4,
    parameter int OUT_FIFO_DEPTH      = 4,
    parameter int RESP_WIDTH          = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH-1:0] matrixes_i,
    input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [RESP_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
`ifdef HT_STATS_EN
    ,
    output logic [4*32-1:0]       stat_o
`endif
);
    localparam int REQ_W = 2 + KEY_WIDTH + DATA_WIDTH;
    localparam int PW    = $clog2(OUT_FIFO_DEPTH);
    localparam int CW    = $clog2(OUT_FIFO_DEPTH + 1);

    if (RESP_WIDTH < DATA_WIDTH + TAG_WIDTH + 4) begin : g_bad_resp_width
        $error("RESP_WIDTH too small for flags, tag and data");
    end

    logic [REQ_W-1:0]       sk_mem [2];
    logic                   sk_wp;
    logic                   sk_rp;
    logic [1:0]             sk_cnt;
    logic [1:0]             sk_cnt_nxt;
    logic [REQ_W-1:0]       head;
    logic [CW-1:0]          credits;
    logic [CW-1:0]          in_flight;
    logic [CW-1:0]          fifo_cnt;
    logic [CW-1:0]          fifo_cnt_nxt;
    logic [TAG_WIDTH-1:0]   tag;
    logic [TAG_WIDTH+1:0]   tf_mem [OUT_FIFO_DEPTH];
    logic [TAG_WIDTH+1:0]   tf_head;
    logic [PW-1:0]          tf_wp;
    logic [PW-1:0]          tf_rp;
    logic [RESP_WIDTH-1:0]  rf_mem [OUT_FIFO_DEPTH];
    logic [PW-1:0]          rf_wp;
    logic [PW-1:0]          rf_rp;
    logic [RESP_WIDTH-1:0]  resp;
    logic                   s_push;
    logic                   issue;
    logic                   m_pop;
    logic                   ht_ready;
    logic                   ht_valid;
    logic [DATA_WIDTH-1:0]  ht_rdata;
    logic [3:0]             ht_flags;

    assign head     = sk_mem[sk_rp];
    assign tf_head  = tf_mem[tf_rp];
    assign s_push   = s_valid_i & s_ready_o;
    assign issue    = (sk_cnt != 2'd0) & (credits != '0) & ht_ready;
    assign m_pop    = m_valid_o & m_ready_i;
    assign m_data_o = m_valid_o ? rf_mem[rf_rp] : '0;

    assign sk_cnt_nxt   = sk_cnt + 2'(s_push) - 2'(issue);
    assign fifo_cnt_nxt = fifo_cnt + CW'(ht_valid) - CW'(m_pop);

    hash_table #(
        .KEY_WIDTH           (KEY_WIDTH),
        .DATA_WIDTH          (DATA_WIDTH),
        .NUMBER_OF_TABLES    (NUMBER_OF_TABLES),
        .HASH_TABLE_MAX_SIZE (HASH_TABLE_MAX_SIZE),
        .HASH_TABLE_SIZES    (HASH_TABLE_SIZES),
        .BUCKET_SIZE         (BUCKET_SIZE),
        .CAM_SIZE            (CAM_SIZE)
    ) u_ht (
        .clk                   (clk),
        .reset                 (reset),
        .matrixes_i            (matrixes_i),
        .valid_i               (issue),
        .ready_o               (ht_ready),
        .op_i                  (head[REQ_W-1 -: 2]),
        .key_i                 (head[DATA_WIDTH +: KEY_WIDTH]),
        .data_i                (head[DATA_WIDTH-1:0]),
        .valid_o               (ht_valid),
        .ready_i               (1'b1),
        .read_data_o           (ht_rdata),
        .key_already_present_o (ht_flags[3]),
        .no_element_found_o    (ht_flags[2]),
        .no_write_space_o      (ht_flags[1]),
        .no_deletion_target_o  (ht_flags[0])
    );

    // Tag FIFO entry is {op, tag}; op masks read data off non-read responses.
    always_comb begin
        resp = '0;
        resp[RESP_WIDTH-1 -: 4]      = ht_flags;
        resp[DATA_WIDTH +: TAG_WIDTH] = tf_head[TAG_WIDTH-1:0];
        if (tf_head[TAG_WIDTH +: 2] == 2'b01) resp[DATA_WIDTH-1:0] = ht_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sk_wp     <= 1'b0;
            sk_rp     <= 1'b0;
            sk_cnt    <= '0;
            s_ready_o <= 1'b0;
            credits   <= CW'(OUT_FIFO_DEPTH);
            in_flight <= '0;
            tag       <= '0;
            tf_wp     <= '0;
            tf_rp     <= '0;
            rf_wp     <= '0;
            rf_rp     <= '0;
            fifo_cnt  <= '0;
            m_valid_o <= 1'b0;
        end else begin
            sk_cnt    <= sk_cnt_nxt;
            s_ready_o <= sk_cnt_nxt != 2'd2;
            if (s_push) begin
                sk_mem[sk_wp] <= s_data_i;
                sk_wp         <= ~sk_wp;
            end
            if (issue) begin
                sk_rp         <= ~sk_rp;
                tf_mem[tf_wp] <= {head[REQ_W-1 -: 2], tag};
                tf_wp         <= tf_wp + PW'(1);
                tag           <= tag + TAG_WIDTH'(1);
            end
            if (ht_valid) begin
                rf_mem[rf_wp] <= resp;
                rf_wp         <= rf_wp + PW'(1);
                tf_rp         <= tf_rp + PW'(1);
            end
            if (m_pop) rf_rp <= rf_rp + PW'(1);
            case ({issue, m_pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: ;
            endcase
            in_flight <= in_flight + CW'(issue) - CW'(ht_valid);
            fifo_cnt  <= fifo_cnt_nxt;
            m_valid_o <= fifo_cnt_nxt != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (int'(credits) + int'(in_flight) + int'(fifo_cnt) == OUT_FIFO_DEPTH);
    end

`ifdef HT_STATS_EN
    logic [31:0] st_rd;
    logic [31:0] st_wr;
    logic [31:0] st_del;
    logic [31:0] st_err;

    assign stat_o = {st_err, st_del, st_wr, st_rd};

    always_ff @(posedge clk) begin
        if (reset) begin
            st_rd  <= '0;
            st_wr  <= '0;
            st_del <= '0;
            st_err <= '0;
        end else if (ht_valid) begin
            case (tf_head[TAG_WIDTH +: 2])
                2'b01:   if (st_rd != '1) st_rd <= st_rd + 32'd1;
                2'b10:   if (st_wr != '1) st_wr <= st_wr + 32'd1;
                2'b11:   if (st_del != '1) st_del <= st_del + 32'd1;
                default: ;
            endcase
            if (|ht_flags && st_err != '1) st_err <= st_err + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hash_table_stream_adapter.sv
// Randomized scoreboard bench for hash_table_stream_adapter.
module tb_hash_table_stream_adapter;
    localparam int KW  = 5;
    localparam int DW  = 25;
    localparam int NT  = 8;
    localparam int MS  = 5;
    localparam int TW  = 4;
    localparam int D   = 4;
    localparam int RW  = 40;
    localparam int CAP = NT * 2 + 8;
    localparam int QW  = 2 + KW + DW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NT*MS*KW-1:0] matrixes_i;
    logic [QW-1:0]     s_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [RW-1:0]     m_data_o;
    logic              m_valid_o;
    logic              m_ready_i = 1'b1;
`ifdef HT_STATS_EN
    logic [127:0]      stat_o;
`endif

    int total = 0;
    int bad = 0;
    logic [RW-1:0] exp_q [$];
    logic [DW-1:0] tbl [int];
    int tag_m = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int first_acc = -1;
    int last_acc = -1;
    int m_rd = 0, m_wr = 0, m_del = 0, m_err = 0;
    logic hold = 1'b0;
    logic [RW-1:0] held = '0;
    logic rnd_done = 1'b0;

    hash_table_stream_adapter dut (
        .clk        (clk),
        .reset      (reset),
        .matrixes_i (matrixes_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i)
`ifdef HT_STATS_EN
        ,
        .stat_o     (stat_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t want finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: a key->value map with fixed capacity, answered in acceptance order.
    function automatic logic [RW-1:0] model(input logic [QW-1:0] req);
        logic [1:0] op;
        int k;
        logic [3:0] fl;
        logic [DW-1:0] rd;
        logic [RW-1:0] r;
        op = req[QW-1 -: 2];
        k = int'(req[DW +: KW]);
        fl = 4'b0;
        rd = '0;
        case (op)
            2'b01: begin
                m_rd++;
                if (tbl.exists(k)) rd = tbl[k];
                else fl[2] = 1'b1;
            end
            2'b10: begin
                m_wr++;
                if (tbl.exists(k)) fl[3] = 1'b1;
                else if (tbl.num() >= CAP) fl[1] = 1'b1;
                else tbl[k] = req[DW-1:0];
            end
            2'b11: begin
                m_del++;
                if (tbl.exists(k)) tbl.delete(k);
                else fl[0] = 1'b1;
            end
            default: ;
        endcase
        if (fl != 4'b0) m_err++;
        r = '0;
        r[RW-1 -: 4] = fl;
        r[DW +: TW] = tag_m[TW-1:0];
        r[DW-1:0] = rd;
        tag_m = (tag_m + 1) % (1 << TW);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && s_valid_i && s_ready_o) begin
            exp_q.push_back(model(s_data_i));
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", RW'(m_valid_o), RW'(1));
                chk("hold_data", m_data_o, held);
            end
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_extra: got %h want none", m_data_o);
                end else begin
                    chk("resp", m_data_o, exp_q.pop_front());
                end
            end
            hold = m_valid_o && !m_ready_i;
            held = m_data_o;
        end
    end

    task automatic send(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d);
        int n;
        n = 0;
        s_valid_i = 1'b1;
        s_data_i = {op, k, d};
        @(negedge clk);
        while (!s_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_o) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready=%b want 1", s_ready_o);
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        s_valid_i = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        tbl.delete();
        tag_m = 0;
        m_rd = 0; m_wr = 0; m_del = 0; m_err = 0;
        @(negedge clk);
        chk("rst_s_ready", RW'(s_ready_o), RW'(0));
        chk("rst_m_valid", RW'(m_valid_o), RW'(0));
        chk("rst_m_data", m_data_o, RW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", RW'(s_ready_o), RW'(1));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(nm, RW'(exp_q.size()), RW'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        matrixes_i = {7{$urandom}};
        do_reset();

        send(2'b10, 5'd5, 25'h1234);
        send(2'b01, 5'd5, 25'h0);
        send(2'b01, 5'd9, 25'h0);
        send(2'b10, 5'd5, 25'h77);
        send(2'b00, 5'd3, 25'h5);
        send(2'b11, 5'd9, 25'h0);
        drain("drain_directed");

        m_ready_i = 1'b0;
        base = acc_cnt;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(2'b10, 5'(i + 10), 25'($urandom));
                rnd_done = 1'b1;
            end
        join_none
        repeat (30) @(negedge clk);
        chk("stall_accepted", RW'(acc_cnt - base), RW'(D + 2));
        chk("stall_ready", RW'(s_ready_o), RW'(0));
        @(posedge clk);
        #1;
        m_ready_i = 1'b1;
        n = 0;
        while (!rnd_done && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("stall_sends_done", RW'(rnd_done), RW'(1));
        #1;
        drain("drain_stall");

        first_acc = -1;
        for (int i = 0; i < 20; i++)
            send(2'($urandom_range(1, 3)), 5'($urandom_range(0, 31)), 25'($urandom));
        chk("burst_no_bubble", RW'(last_acc - first_acc), RW'(19));
        drain("drain_burst");

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 25'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    m_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready_i = 1'b1;
        drain("drain_random");

        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(2'b10, 5'(i), 25'(i + 100));
        do_reset();
        m_ready_i = 1'b1;
        send(2'b01, 5'd2, 25'h0);
        drain("drain_after_reset");

`ifdef HT_STATS_EN
        do_reset();
        send(2'b10, 5'd1, 25'h11);
        send(2'b10, 5'd2, 25'h22);
        send(2'b01, 5'd1, 25'h0);
        send(2'b01, 5'd2, 25'h0);
        send(2'b01, 5'd2, 25'h0);
        send(2'b11, 5'd7, 25'h0);
        drain("drain_stats");
        chk("stats_fixed", stat_o[RW-1:0], RW'({32'd2, 32'd3}));
        chk("stats_hi", RW'(stat_o[127:64]), RW'({32'd1, 32'd1}));
        chk("stats_model", RW'(stat_o[31:0]), RW'(m_rd));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
